// File: rtl/lsu_mem_port_pkg.sv
// Shared types for the LSU memory port: size encodings, FSM states, latched request payload.
package lsu_mem_port_pkg;

    localparam int unsigned DATA_W = 64;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_MRG,
        ST_WR,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic              write;
        logic [1:0]        size;
        logic              is_unsigned;
        logic [2:0]        offset;
        logic [DATA_W-1:0] wdata;
    } lsu_req_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Request/response and data_memory signals of the LSU; master = requester/memory side, slave = LSU.
interface lsu_mem_port_if
    import lsu_mem_port_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned ADDR_W = 6
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [XLEN-1:0]   req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              memWrite;
    logic              memRead;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writeData;
    logic [DATA_W-1:0] readData;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, readData,
        input  req_ready, resp_valid, resp_rdata, resp_err, memWrite, memRead, address, writeData
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, readData,
        output req_ready, resp_valid, resp_rdata, resp_err, memWrite, memRead, address, writeData
    );
endinterface

// File: rtl/lsu_byte_lane.sv
// Byte-lane datapath: load extract + sign/zero extend, and store merge into a doubleword.
module lsu_byte_lane
    import lsu_mem_port_pkg::*;
(
    input  logic [DATA_W-1:0] dword_i,
    input  logic [2:0]        offset_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] load_c_o,
    output logic [DATA_W-1:0] merge_c_o
);
    logic [5:0]        shamt_c;
    logic [DATA_W-1:0] shifted_c;
    logic [DATA_W-1:0] lane_mask_c;
    logic [DATA_W-1:0] place_mask_c;
    logic              sign_c;

    assign shamt_c = {offset_i, 3'b000};

    always_comb begin
        shifted_c   = dword_i >> shamt_c;
        lane_mask_c = '1;
        sign_c      = 1'b0;
        case (size_i)
            SZ_B: begin lane_mask_c = 64'h0000_0000_0000_00FF; sign_c = shifted_c[7];  end
            SZ_H: begin lane_mask_c = 64'h0000_0000_0000_FFFF; sign_c = shifted_c[15]; end
            SZ_W: begin lane_mask_c = 64'h0000_0000_FFFF_FFFF; sign_c = shifted_c[31]; end
            default: ;
        endcase
        place_mask_c = lane_mask_c << shamt_c;
        // D has an all-ones mask, so the extension term vanishes for it.
        load_c_o  = (shifted_c & lane_mask_c) |
                    ({DATA_W{sign_c & ~unsigned_i}} & ~lane_mask_c);
        merge_c_o = (dword_i & ~place_mask_c) | ((wdata_i << shamt_c) & place_mask_c);
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Byte-addressed load/store unit driving a doubleword data_memory port, RMW for sub-D stores.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses respond with resp_err and no memory cycles.
module lsu_mem_port
    import lsu_mem_port_pkg::*;
#(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned ADDR_W       = 6,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    lsu_mem_port_if.slave  bus
);
    localparam int unsigned CNT_W = 1;

    state_e            state_q, state_d;
    lsu_req_t          req_q, req_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;

    logic [ADDR_W-1:0] index_c;
    logic [2:0]        align_mask_c;
    logic [2:0]        offset_c;
    logic              misalign_c;
    logic [DATA_W-1:0] lane_dword_c;
    logic [DATA_W-1:0] load_c;
    logic [DATA_W-1:0] merge_c;
    logic              unused_addr;

    // Upper address bits wrap away.
    assign index_c      = bus.req_addr[ADDR_W+2:3];
    assign unused_addr  = ^{bus.req_addr[XLEN-1:ADDR_W+3]};
    assign align_mask_c = 3'(size_bytes(bus.req_size) - 4'd1);

`ifdef LSU_MISALIGN_TRAP_EN
    assign offset_c   = bus.req_addr[2:0];
    assign misalign_c = |(bus.req_addr[2:0] & align_mask_c);
`else
    assign offset_c   = bus.req_addr[2:0] & ~align_mask_c;
    assign misalign_c = 1'b0;
`endif

    // Loads extract straight from readData; merges use the doubleword sampled in RD.
    assign lane_dword_c = (state_q == ST_RD) ? bus.readData : rdata_q;

    lsu_byte_lane u_lane (
        .dword_i    (lane_dword_c),
        .offset_i   (req_q.offset),
        .size_i     (req_q.size),
        .unsigned_i (req_q.is_unsigned),
        .wdata_i    (req_q.wdata),
        .load_c_o   (load_c),
        .merge_c_o  (merge_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            rd_cnt_q     <= '0;
            rdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            address_q    <= '0;
            write_data_q <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            rd_cnt_q     <= rd_cnt_d;
            rdata_q      <= rdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
        end
    end

    // Next state; every output register is loaded with its value for the upcoming state.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        rd_cnt_d     = rd_cnt_q;
        rdata_d      = rdata_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        address_d    = address_q;
        write_data_d = write_data_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    req_d.write       = bus.req_write;
                    req_d.size        = bus.req_size;
                    req_d.is_unsigned = bus.req_unsigned;
                    req_d.offset      = offset_c;
                    req_d.wdata       = bus.req_wdata;
                    if (misalign_c) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else if (bus.req_write && (bus.req_size == SZ_D)) begin
                        state_d      = ST_WR;
                        mem_write_d  = 1'b1;
                        address_d    = index_c;
                        write_data_d = bus.req_wdata;
                    end else begin
                        state_d    = ST_RD;
                        mem_read_d = 1'b1;
                        address_d  = index_c;
                        rd_cnt_d   = '0;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            ST_RD: begin
                if (rd_cnt_q == CNT_W'(READ_LATENCY)) begin
                    if (req_q.write) begin
                        state_d = ST_MRG;
                        rdata_d = bus.readData;
                    end else begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = load_c;
                    end
                end else begin
                    mem_read_d = 1'b1;
                    rd_cnt_d   = rd_cnt_q + 1'b1;
                end
            end
            ST_MRG: begin
                state_d      = ST_WR;
                mem_write_d  = 1'b1;
                write_data_d = merge_c;
            end
            ST_WR: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = '0;
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.memRead    = mem_read_q;
    assign bus.memWrite   = mem_write_q;
    assign bus.address    = address_q;
    assign bus.writeData  = write_data_q;

endmodule
